// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU control codes, arbiter
// state encoding and default widths.
package alu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 4;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_EXEC = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// port named by ptr_i.
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);

   assign gnt_o[0] = valid_i[0] & (~valid_i[1] | ~ptr_i);
   assign gnt_o[1] = valid_i[1] & (~valid_i[0] |  ptr_i);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX stage (port 0) and the branch/
// address helper (port 1). Optional statistics counters: ALU_ARB_STATS_EN.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [CNT_W-1:0]  grant0_cnt,
   output logic [CNT_W-1:0]  grant1_cnt,
   output logic [CNT_W-1:0]  conflict_cnt
`endif
);

   arb_state_e        state_q;
   logic              owner_q;
   logic              rr_ptr_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q, rsp_result_q;
   logic [CTRL_W-1:0] alu_ctrl_q;
   logic              rsp_zero_q, rsp0_valid_q, rsp1_valid_q;
   logic [1:0]        gnt;
   logic              idle;

   rr_arb2 u_rr_arb2 (
      .valid_i ({req1_valid, req0_valid}),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (gnt)
   );

   // Gated with rst_n so every output reads 0 while reset is held.
   assign idle       = rst_n & (state_q == ARB_IDLE);
   assign req0_ready = idle & gnt[0];
   assign req1_ready = idle & gnt[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         owner_q      <= 1'b0;
         rr_ptr_q     <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (|gnt) begin
                  alu_a_q    <= gnt[1] ? req1_a    : req0_a;
                  alu_b_q    <= gnt[1] ? req1_b    : req0_b;
                  alu_ctrl_q <= gnt[1] ? req1_ctrl : req0_ctrl;
                  owner_q    <= gnt[1];
                  state_q    <= ARB_EXEC;
               end
            end
            ARB_EXEC: begin
               rsp_result_q <= alu_out;
               rsp_zero_q   <= alu_zero;
               rsp0_valid_q <= ~owner_q;
               rsp1_valid_q <= owner_q;
               state_q      <= ARB_RESP;
            end
            ARB_RESP: begin
               // The served port loses priority on the next tie.
               if (owner_q ? rsp1_ready : rsp0_ready) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  rr_ptr_q     <= ~owner_q;
                  state_q      <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] grant0_cnt_q, grant1_cnt_q, conflict_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant0_cnt_q   <= '0;
         grant1_cnt_q   <= '0;
         conflict_cnt_q <= '0;
      end else if (stats_clr) begin
         grant0_cnt_q   <= '0;
         grant1_cnt_q   <= '0;
         conflict_cnt_q <= '0;
      end else begin
         if (req0_valid && req0_ready && !(&grant0_cnt_q))
            grant0_cnt_q <= grant0_cnt_q + 1'b1;
         if (req1_valid && req1_ready && !(&grant1_cnt_q))
            grant1_cnt_q <= grant1_cnt_q + 1'b1;
         if (idle && req0_valid && req1_valid && !(&conflict_cnt_q))
            conflict_cnt_q <= conflict_cnt_q + 1'b1;
      end
   end

   assign grant0_cnt   = grant0_cnt_q;
   assign grant1_cnt   = grant1_cnt_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios plus randomized
// traffic, checked by a request-level reference model in a separate monitor.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_v = '0;
   logic [31:0] req_a [2];
   logic [31:0] req_b [2];
   logic [3:0]  req_c [2];
   logic [1:0]  rsp_rdy = 2'b11;
   logic        r0, r1, v0, v1, rsp_zero, alu_zero;
   logic [31:0] rsp_result, alu_a, alu_b, alu_out;
   logic [3:0]  alu_ctrl;
   wire  [1:0]  rdy = {r1, r0};
   wire  [1:0]  rv  = {v1, v0};
`ifdef ALU_ARB_STATS_EN
   logic        stats_clr = 1'b0;
   logic [CW-1:0] g0c, g1c, cfc;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a;
      endcase
   endfunction

   // Stand-in for the external ALU instance.
   assign alu_out  = alu_fn(alu_ctrl, alu_a, alu_b);
   assign alu_zero = (alu_ctrl == ALU_SUB) && (alu_a == alu_b);

   alu_share_arbiter #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req_v[0]), .req0_ready(r0), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_ctrl(req_c[0]),
      .req1_valid(req_v[1]), .req1_ready(r1), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_ctrl(req_c[1]),
      .rsp0_valid(v0), .rsp0_ready(rsp_rdy[0]), .rsp1_valid(v1), .rsp1_ready(rsp_rdy[1]),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_zero(alu_zero)
`ifdef ALU_ARB_STATS_EN
      , .stats_clr(stats_clr), .grant0_cnt(g0c), .grant1_cnt(g1c), .conflict_cnt(cfc)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   typedef struct packed { logic [31:0] res; logic z; } exp_t;
   exp_t        q0[$], q1[$];
   int          cyc = 0, acc_cyc = 0, own = 0;
   bit          busy = 0, model_ptr = 0, rsp_seen = 0;
   logic [31:0] held_res;
   logic        held_z;
   int          gnt_log[$];

   always @(negedge clk) begin
      logic [1:0] exp_g, exp_rv;
      exp_t e, got;
      cyc++;
      if (!rst_n) begin
         q0.delete(); q1.delete();
         busy = 0; model_ptr = 0; rsp_seen = 0;
      end else begin
         if (req_v != 2'b00) begin
            if (busy) chk("ready_while_busy", {30'd0, rdy}, 32'd0);
            else begin
               exp_g = (req_v == 2'b11) ? (model_ptr ? 2'b10 : 2'b01) : req_v;
               chk("grant", {30'd0, rdy}, {30'd0, exp_g});
               if ((rdy & req_v) != 2'b00) begin
                  own = rdy[1] ? 1 : 0;
                  e.res = alu_fn(req_c[own], req_a[own], req_b[own]);
                  e.z   = (req_c[own] == ALU_SUB) && (req_a[own] == req_b[own]);
                  if (own == 0) q0.push_back(e); else q1.push_back(e);
                  busy = 1; acc_cyc = cyc; rsp_seen = 0;
                  gnt_log.push_back(own);
               end
            end
         end
         exp_rv = (busy && cyc >= acc_cyc + 2) ? (own == 1 ? 2'b10 : 2'b01) : 2'b00;
         if (rv != 2'b00 || exp_rv != 2'b00) chk("rsp_valid", {30'd0, rv}, {30'd0, exp_rv});
         if (rv != 2'b00 && rv == exp_rv) begin
            if (rsp_seen) begin
               chk("rsp_stable_res", rsp_result, held_res);
               chk("rsp_stable_z", {31'd0, rsp_zero}, {31'd0, held_z});
            end
            rsp_seen = 1; held_res = rsp_result; held_z = rsp_zero;
            if (rsp_rdy[own]) begin
               if ((own == 0 ? q0.size() : q1.size()) == 0) chk("sb_underflow", 32'd1, 32'd0);
               else begin
                  got = (own == 0) ? q0.pop_front() : q1.pop_front();
                  chk("rsp_result", rsp_result, got.res);
                  chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, got.z});
               end
               busy = 0; rsp_seen = 0; model_ptr = (own == 0);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      req_v = '0; rsp_rdy = 2'b11; rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic set_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      req_c[p] = c; req_a[p] = a; req_b[p] = b;
   endtask

   task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      bit got = 0;
      set_op(p, c, a, b);
      req_v[p] = 1'b1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (rdy[p]) got = 1;
      end
      if (!got) chk("issue_timeout", 32'd0, 32'd1);
      @(posedge clk); #1 req_v[p] = 1'b0;
   endtask

   task automatic wait_rsp(input int p, input string nm, input logic [31:0] res, input logic z);
      bit got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (rv[p]) got = 1;
      end
      chk({nm, "_seen"}, {31'd0, got}, 32'd1);
      chk({nm, "_res"}, rsp_result, res);
      chk({nm, "_zero"}, {31'd0, rsp_zero}, {31'd0, z});
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!busy && q0.size() == 0 && q1.size() == 0) done = 1;
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic contend(input int n);
      bit done = 0;
      set_op(0, ALU_AND, 32'hF0, 32'h3C);
      set_op(1, ALU_OR,  32'hF0, 32'h0C);
      req_v = 2'b11;
      for (int i = 0; i < 20 * n && !done; i++) begin
         @(negedge clk);
         if (gnt_log.size() >= n) done = 1;
      end
      if (!done) chk("contend_timeout", 32'd0, 32'd1);
      @(posedge clk); #1 req_v = 2'b00;
      wait_idle();
   endtask

   task automatic rand_drv(input int p, input int n);
      bit acc;
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         acc = rdy[p] && req_v[p];
         @(posedge clk); #1;
         if (acc || !req_v[p]) begin
            if ($urandom_range(2, 0) == 0 || acc) begin
               a = $urandom;
               case ($urandom_range(5, 0))
                  0: req_c[p] = ALU_AND;
                  1: req_c[p] = ALU_OR;
                  2: req_c[p] = ALU_ADD;
                  3: req_c[p] = ALU_SUB;
                  4: req_c[p] = ALU_SLT;
                  default: req_c[p] = 4'($urandom);
               endcase
               req_a[p] = a;
               req_b[p] = ($urandom_range(3, 0) == 0) ? a : $urandom;
               req_v[p] = ($urandom_range(1, 0) == 1);
            end
         end else if ($urandom_range(7, 0) == 0) begin
            req_v[p] = 1'b0;
         end
      end
   endtask

   task automatic rand_rdy(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 rsp_rdy = 2'($urandom);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] cap;
      for (int p = 0; p < 2; p++) set_op(p, 4'h0, 32'h0, 32'h0);

      // reset values
      #3;
      chk("rst_ready", {30'd0, rdy}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rv}, 32'd0);
      chk("rst_result", rsp_result, 32'd0);
      chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      do_reset();

      // single requests
      issue(0, ALU_ADD, 32'd5, 32'd7);
      wait_rsp(0, "add_5_7", 32'd12, 1'b0);
      wait_idle();
      issue(1, ALU_SUB, 32'h1234, 32'h1234);
      wait_rsp(1, "sub_eq", 32'd0, 1'b1);
      wait_idle();
      issue(1, ALU_SUB, 32'd9, 32'd3);
      wait_rsp(1, "sub_9_3", 32'd6, 1'b0);
      wait_idle();

      // contention: alternating grants
      do_reset();
      gnt_log.delete();
      contend(6);
      for (int i = 0; i < 6; i++) chk("alt_grant", gnt_log[i], i % 2);
      for (int i = 1; i < 6; i++) chk("no_repeat_grant", {31'd0, gnt_log[i] == gnt_log[i-1]}, 32'd0);

      // response backpressure
      rsp_rdy = 2'b10;
      issue(0, ALU_ADD, 32'd100, 32'd23);
      set_op(1, ALU_OR, 32'h5, 32'hA);
      req_v[1] = 1'b1;
      wait_rsp(0, "bp_first", 32'd123, 1'b0);
      cap = rsp_result;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_held", {31'd0, v0}, 32'd1);
         chk("bp_result_held", rsp_result, cap);
         chk("bp_req1_blocked", {31'd0, r1}, 32'd0);
      end
      @(posedge clk); #1 rsp_rdy = 2'b11;
      @(negedge clk);
      @(negedge clk);
      chk("bp_req1_grant", {31'd0, r1}, 32'd1);
      @(posedge clk); #1 req_v[1] = 1'b0;
      wait_idle();

      // reset during EXEC
      issue(0, ALU_ADD, 32'd3, 32'd4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", {30'd0, rv}, 32'd0);
      chk("mid_rst_alu_a", alu_a, 32'd0);
      chk("mid_rst_alu_b", alu_b, 32'd0);
      chk("mid_rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      chk("mid_rst_result", rsp_result, 32'd0);
      @(negedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      issue(0, ALU_ADD, 32'd1, 32'd1);
      wait_rsp(0, "post_rst_add", 32'd2, 1'b0);
      wait_idle();

      // randomized traffic
      fork
         rand_drv(0, 600);
         rand_drv(1, 600);
         rand_rdy(600);
      join
      req_v = 2'b00; rsp_rdy = 2'b11;
      wait_idle();

`ifdef ALU_ARB_STATS_EN
      do_reset();
      gnt_log.delete();
      contend(6);
      chk("stats_g0", {28'd0, g0c}, 32'd3);
      chk("stats_g1", {28'd0, g1c}, 32'd3);
      chk("stats_conflict_min", {31'd0, cfc >= 4'd3}, 32'd1);
      gnt_log.delete();
      contend(40);
      chk("stats_g0_sat", {28'd0, g0c}, 32'd15);
      chk("stats_g1_sat", {28'd0, g1c}, 32'd15);
      chk("stats_conflict_sat", {28'd0, cfc}, 32'd15);
      stats_clr = 1'b1;
      @(posedge clk); #1 stats_clr = 1'b0;
      chk("stats_clr_g0", {28'd0, g0c}, 32'd0);
      chk("stats_clr_g1", {28'd0, g1c}, 32'd0);
      chk("stats_clr_conflict", {28'd0, cfc}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
